// File: rtl/memstage_lsu_pkg.sv
// memstage_lsu shared definitions: rv32i func codes, FSM states, decode helpers.
// Every stage of the slice takes its op codes from this package.
package memstage_lsu_pkg;

    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] LB  = 6'h01;
    localparam logic [5:0] LH  = 6'h02;
    localparam logic [5:0] LW  = 6'h03;
    localparam logic [5:0] LBU = 6'h04;
    localparam logic [5:0] LHU = 6'h05;
    localparam logic [5:0] SB  = 6'h08;
    localparam logic [5:0] SH  = 6'h09;
    localparam logic [5:0] SW  = 6'h0A;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    function automatic size_t op_size(input logic [5:0] f);
        case (f)
            LB:      op_size = SZ_B;
            LBU:     op_size = SZ_B;
            SB:      op_size = SZ_B;
            LH:      op_size = SZ_H;
            LHU:     op_size = SZ_H;
            SH:      op_size = SZ_H;
            LW:      op_size = SZ_W;
            SW:      op_size = SZ_W;
            default: op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_store(input logic [5:0] f);
        case (f)
            SB:      op_store = 1'b1;
            SH:      op_store = 1'b1;
            SW:      op_store = 1'b1;
            default: op_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memstage_lsu_if.sv
// Memory-side request/ack bus of the load/store unit.
// master = LSU, slave = memory.
interface memstage_lsu_if #(
    parameter int XLEN = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memstage_lsu_align.sv
// Byte-lane steering for the LSU: store be/replication and load extraction.
// Purely combinational; both directions share the lane offset math.
module lsu_align
    import memstage_lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [5:0]      st_func,
    input  logic [OFFW-1:0] st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [NB-1:0]   be,
    output logic [XLEN-1:0] wdata,
    input  logic [5:0]      ld_func,
    input  logic [OFFW-1:0] ld_off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);
    logic [XLEN-1:0] sh;

    always_comb begin
        be    = '0;
        wdata = st_data;
        case (op_size(st_func))
            SZ_B: begin
                be    = NB'(1) << st_off;
                wdata = {NB{st_data[7:0]}};
            end
            SZ_H: begin
                be    = NB'(3) << st_off;
                wdata = {(NB/2){st_data[15:0]}};
            end
            SZ_W: begin
                be    = NB'(15) << st_off;
                wdata = {(NB/4){st_data[31:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign sh = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = rdata;
        case (ld_func)
            LB:      ld_data = XLEN'($signed(sh[7:0]));
            LBU:     ld_data = XLEN'(sh[7:0]);
            LH:      ld_data = XLEN'($signed(sh[15:0]));
            LHU:     ld_data = XLEN'(sh[15:0]);
            LW:      ld_data = XLEN'($signed(sh[31:0]));
            default: ;
        endcase
    end
endmodule

// File: rtl/memstage_lsu_reg0.sv
// Enable register with asynchronous active-high clear to zero.
// Holds the captured op fields of the memory stage.
module reg0 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/memstage_lsu.sv
// Memory stage: pass-through for ALU results, load/store unit with
// lane alignment, misalignment faults and a request timeout watchdog.
module memstage_lsu
    import memstage_lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      rd,
    input  logic [5:0]      func,
    memstage_lsu_if.master  mem,
    output logic            wb_valid,
    output logic [XLEN-1:0] data_out,
    output logic [4:0]      rd_out,
    output logic [5:0]      func_out,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(MAX_WAIT + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   wait_cnt;
    size_t           in_sz;
    logic            accept, misalign, go_mem, done, timeout;
    logic [XLEN-1:0] q_addr, q_data;
    logic [4:0]      q_rd;
    logic [5:0]      q_func;
    logic [NB-1:0]   st_be;
    logic [XLEN-1:0] st_wdata, ld_data;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign in_sz    = op_size(func);
    assign misalign = (in_sz == SZ_H && addr_in[0])
                   || (in_sz == SZ_W && addr_in[1:0] != 2'b00);
    assign go_mem   = accept && in_sz != SZ_NONE && !misalign;
    assign done     = (state == REQ) && mem.mem_ack;
    // An ack in the final wait cycle takes priority over the abort.
    assign timeout  = (state == REQ) && !mem.mem_ack
                   && wait_cnt == CW'(MAX_WAIT - 1);

    reg0 #(.W(XLEN)) u_addr (
        .clk(clk), .rst(rst), .en(accept), .d(addr_in), .q(q_addr)
    );
    reg0 #(.W(XLEN)) u_data (
        .clk(clk), .rst(rst), .en(accept), .d(data_in), .q(q_data)
    );
    reg0 #(.W(5)) u_rd (
        .clk(clk), .rst(rst), .en(accept), .d(rd), .q(q_rd)
    );
    reg0 #(.W(6)) u_func (
        .clk(clk), .rst(rst), .en(accept), .d(func), .q(q_func)
    );

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_func (func),
        .st_off  (addr_in[OFFW-1:0]),
        .st_data (data_in),
        .be      (st_be),
        .wdata   (st_wdata),
        .ld_func (q_func),
        .ld_off  (q_addr[OFFW-1:0]),
        .rdata   (mem.mem_rdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go_mem) state_nx = REQ;
            REQ:     if (done || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            wait_cnt      <= '0;
        end else begin
            if (go_mem) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= op_store(func);
                mem.mem_be    <= st_be;
                mem.mem_addr  <= {addr_in[XLEN-1:OFFW], {OFFW{1'b0}}};
                mem.mem_wdata <= st_wdata;
                wait_cnt      <= '0;
            end else if (done || timeout) begin
                mem.mem_req <= 1'b0;
            end
            if (state == REQ && !mem.mem_ack)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            data_out   <= '0;
            rd_out     <= '0;
            func_out   <= NOP;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            unique case (1'b1)
                accept && in_sz == SZ_NONE: begin
                    wb_valid <= 1'b1;
                    data_out <= data_in;
                    rd_out   <= rd;
                    func_out <= func;
                end
                accept && misalign: begin
                    fault      <= 1'b1;
                    fault_addr <= addr_in;
                    func_out   <= NOP;
                end
                done: begin
                    wb_valid <= 1'b1;
                    data_out <= op_store(q_func) ? q_data : ld_data;
                    rd_out   <= q_rd;
                    func_out <= q_func;
                end
                timeout: begin
                    fault      <= 1'b1;
                    fault_addr <= q_addr;
                    func_out   <= NOP;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memstage_lsu.sv
// Directed bench for memstage_lsu with a writeback scoreboard.
// Memory side is driven by hand so ack timing is exact per step.
module tb_memstage_lsu;
    import memstage_lsu_pkg::*;

    localparam logic [5:0] ALU_OP = 6'h10;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [5:0]  func;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic        wb_valid;
    logic [31:0] data_out;
    logic [4:0]  rd_out;
    logic [5:0]  func_out;
    logic        fault;
    logic [31:0] fault_addr;

    int checks   = 0;
    int failures = 0;
    wb_t sb[$];

    memstage_lsu_if #(.XLEN(32)) mbus ();

    memstage_lsu #(.XLEN(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .rd         (rd),
        .func       (func),
        .mem        (mbus),
        .wb_valid   (wb_valid),
        .data_out   (data_out),
        .rd_out     (rd_out),
        .func_out   (func_out),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_data", 64'(data_out), 64'(e.data));
                chk("wb_rd", 64'(rd_out), 64'(e.rd));
                chk("wb_func", 64'(func_out), 64'(e.func));
            end
        end
    end

    task automatic mem_op(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] r, input logic [31:0] rdat,
                          input int k, input logic [31:0] exp_data,
                          input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic exp_we,
                          input logic [31:0] exp_wdata);
        wb_t e;
        e.data = exp_data;
        e.rd   = r;
        e.func = f;
        sb.push_back(e);
        in_valid = 1'b1;
        func     = f;
        addr_in  = a;
        data_in  = d;
        rd       = r;
        tick();
        in_valid = 1'b0;
        func     = NOP;
        chk({tag, "_addr"}, 64'(mbus.mem_addr), 64'(exp_addr));
        chk({tag, "_be"}, 64'(mbus.mem_be), 64'(exp_be));
        chk({tag, "_we"}, 64'(mbus.mem_we), 64'(exp_we));
        if (exp_we)
            chk({tag, "_wdata"}, 64'(mbus.mem_wdata), 64'(exp_wdata));
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        for (int c = 1; c < k; c++) begin
            chk({tag, "_req_wait"}, 64'(mbus.mem_req), 64'd1);
            tick();
        end
        chk({tag, "_req_ack"}, 64'(mbus.mem_req), 64'd1);
        mbus.mem_ack   = 1'b1;
        mbus.mem_rdata = rdat;
        tick();
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
        chk({tag, "_req_done"}, 64'(mbus.mem_req), 64'd0);
        chk({tag, "_nofault"}, 64'(fault), 64'd0);
        chk({tag, "_ready_done"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        in_valid       = 1'b0;
        addr_in        = '0;
        data_in        = '0;
        rd             = '0;
        func           = NOP;
        mbus.mem_ack   = 1'b0;
        mbus.mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_req", 64'(mbus.mem_req), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_func_out", 64'(func_out), 64'(NOP));
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_fault_addr", 64'(fault_addr), 64'd0);

        for (int i = 0; i < 4; i++) begin
            wb_t e;
            e.data = 32'h11 * (i + 1);
            e.rd   = 5'(i + 1);
            e.func = ALU_OP;
            sb.push_back(e);
            in_valid = 1'b1;
            func     = ALU_OP;
            data_in  = e.data;
            addr_in  = 32'h100 + 32'(i);
            rd       = e.rd;
            tick();
            chk("pass_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        func     = NOP;
        tick();
        chk("pass_drained", 64'(sb.size()), 64'd0);

        mem_op("lb", LB, 32'h1003, 32'h0, 5'd5, 32'h80FF_FFFF, 3,
               32'hFFFF_FF80, 32'h1000, 4'b1000, 1'b0, 32'h0);
        mem_op("lbu", LBU, 32'h1003, 32'h0, 5'd6, 32'h80FF_FFFF, 3,
               32'h0000_0080, 32'h1000, 4'b1000, 1'b0, 32'h0);
        mem_op("lh", LH, 32'h1002, 32'h0, 5'd7, 32'h8001_0000, 2,
               32'hFFFF_8001, 32'h1000, 4'b1100, 1'b0, 32'h0);
        mem_op("lhu", LHU, 32'h1002, 32'h0, 5'd8, 32'h8001_0000, 1,
               32'h0000_8001, 32'h1000, 4'b1100, 1'b0, 32'h0);
        mem_op("sh", SH, 32'h2002, 32'hABCD_1234, 5'd9, 32'h0, 1,
               32'hABCD_1234, 32'h2000, 4'b1100, 1'b1, 32'h1234_1234);
        mem_op("sb", SB, 32'h5001, 32'h0000_00A5, 5'd10, 32'h0, 2,
               32'h0000_00A5, 32'h5000, 4'b0010, 1'b1, 32'hA5A5_A5A5);
        mem_op("sw", SW, 32'h5004, 32'hCAFE_F00D, 5'd11, 32'h0, 1,
               32'hCAFE_F00D, 32'h5004, 4'b1111, 1'b1, 32'hCAFE_F00D);

        in_valid = 1'b1;
        func     = LW;
        addr_in  = 32'h3002;
        rd       = 5'd12;
        tick();
        in_valid = 1'b0;
        func     = NOP;
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_fault_addr", 64'(fault_addr), 64'h3002);
        chk("mis_req", 64'(mbus.mem_req), 64'd0);
        chk("mis_wb_valid", 64'(wb_valid), 64'd0);
        chk("mis_func_out", 64'(func_out), 64'(NOP));
        chk("mis_ready", 64'(in_ready), 64'd1);
        tick();
        chk("mis_pulse", 64'(fault), 64'd0);
        chk("mis_addr_hold", 64'(fault_addr), 64'h3002);

        in_valid = 1'b1;
        func     = LW;
        addr_in  = 32'h4000;
        rd       = 5'd13;
        tick();
        in_valid = 1'b0;
        func     = NOP;
        n = 0;
        while (mbus.mem_req && n < 10) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 64'(n), 64'd4);
        chk("to_fault", 64'(fault), 64'd1);
        chk("to_fault_addr", 64'(fault_addr), 64'h4000);
        chk("to_wb_valid", 64'(wb_valid), 64'd0);
        chk("to_ready", 64'(in_ready), 64'd1);
        tick();
        chk("to_pulse", 64'(fault), 64'd0);

        mem_op("lw_late", LW, 32'h4000, 32'h0, 5'd14, 32'hDEAD_BEEF, 4,
               32'hDEAD_BEEF, 32'h4000, 4'b1111, 1'b0, 32'h0);

        in_valid = 1'b1;
        func     = LW;
        addr_in  = 32'h6000;
        rd       = 5'd15;
        tick();
        in_valid = 1'b0;
        func     = NOP;
        chk("rr_req_on", 64'(mbus.mem_req), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rr_req_async", 64'(mbus.mem_req), 64'd0);
        mbus.mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mbus.mem_ack = 1'b0;
        chk("rr_ready", 64'(in_ready), 64'd1);
        chk("rr_req_off", 64'(mbus.mem_req), 64'd0);
        chk("rr_func_out", 64'(func_out), 64'(NOP));
        chk("rr_wb_valid", 64'(wb_valid), 64'd0);
        chk("rr_fault", 64'(fault), 64'd0);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
